// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Registered operand-B stage for the execute path. Selects between the
//   forwarded rs2 value and an extended immediate, and holds the result behind
//   a valid/ready handshake. The forwarded rs2 value is also registered on its
//   own for stores.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready = !out_valid || out_ready
//   readData2           register-file rs2 value
//   imm, imm_mode       raw immediate and extension mode
//                       (00 zext, 01 sext, 10 upper, 11 sext<<2)
//   ALUsrc              0: forwarded rs2, 1: extended immediate
//   fwd_hit, fwd_data   forwarding sources, index 0 has highest priority
//   flush               drop the held operand and ignore this cycle's input
//   out_valid/out_ready downstream handshake
//   b                   registered ALU operand B
//   store_data          registered forwarded rs2
//   b_from_imm          registered ALUsrc of the held operand

module alu_operand_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         readData2,
  input  logic [IMM_W-1:0]         imm,
  input  logic [1:0]               imm_mode,
  input  logic                     ALUsrc,
  input  logic [NUM_FWD-1:0]       fwd_hit,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         store_data,
  output logic                     b_from_imm
);

  localparam int unsigned UPPER_SH = WIDTH - IMM_W;
  localparam int unsigned FWD_W    = NUM_FWD * WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] store_data;
    logic             b_from_imm;
  } opnd_t;

  state_t           state_q;
  state_t           state_d;
  logic             load_en;
  opnd_t            opnd_d;
  opnd_t            opnd_q;

  logic [WIDTH-1:0] rs2_eff;
  logic [WIDTH-1:0] imm_zext;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_ext;

  // Forwarding priority: walk sources from index 0 upward, first hit wins.
  logic [NUM_FWD-1:0] hit_scan;
  logic [FWD_W-1:0]   data_scan;
  logic               fwd_found;

  always_comb begin
    rs2_eff   = readData2;
    fwd_found = 1'b0;
    hit_scan  = fwd_hit;
    data_scan = fwd_data;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      if (hit_scan[0] && !fwd_found) begin
        rs2_eff   = data_scan[WIDTH-1:0];
        fwd_found = 1'b1;
      end
      hit_scan  = hit_scan >> 1;
      data_scan = data_scan >> WIDTH;
    end
  end

  // Immediate extension; the signed cast sign-extends from bit IMM_W-1.
  always_comb begin
    imm_zext = WIDTH'(imm);
    imm_sext = WIDTH'($signed(imm));
    imm_ext  = imm_zext;
    case (imm_mode)
      2'b00:   imm_ext = imm_zext;
      2'b01:   imm_ext = imm_sext;
      2'b10:   imm_ext = imm_zext << UPPER_SH;
      2'b11:   imm_ext = imm_sext << 2;
      default: imm_ext = imm_zext;
    endcase
  end

  // Payload captured on accept.
  always_comb begin
    opnd_d            = opnd_q;
    opnd_d.b          = ALUsrc ? imm_ext : rs2_eff;
    opnd_d.store_data = rs2_eff;
    opnd_d.b_from_imm = ALUsrc;
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and load enable; flush overrides any accept.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!flush && in_valid) begin
          load_en = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (out_ready) begin
          if (in_valid) begin
            load_en = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Data registers only toggle on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
    end else if (load_en) begin
      opnd_q <= opnd_d;
    end
  end

  assign in_ready   = (state_q == ST_EMPTY) || out_ready;
  assign out_valid  = (state_q == ST_FULL);
  assign b          = opnd_q.b;
  assign store_data = opnd_q.store_data;
  assign b_from_imm = opnd_q.b_from_imm;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised, registered operand-B stage for the KGPminiRISC execute path. It forms the ALU second operand by choosing between the register-file value (after forwarding) and an extended immediate, then registers the result behind a valid/ready handshake. It sits between decode/register-read and the ALU. It also provides the forwarded rs2 value separately for stores.

## Interface
- WIDTH, 32, datapath width in bits
- IMM_W, 16, raw immediate width; constraint 1 <= IMM_W <= WIDTH
- NUM_FWD, 2, number of forwarding sources (>= 1); index 0 is highest priority (youngest producer)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an operand request
- in_ready  out  1  stage accepts a request this cycle
- readData2  in  WIDTH  register-file rs2 value
- imm  in  IMM_W  raw immediate field
- imm_mode  in  2  00 zero-ext, 01 sign-ext, 10 upper placement, 11 sign-ext then <<2
- ALUsrc  in  1  0 selects forwarded rs2, 1 selects extended immediate
- fwd_hit  in  NUM_FWD  bit i set: source i holds a newer rs2 value
- fwd_data  in  NUM_FWD*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- flush  in  1  discard the held and incoming operand
- out_valid  out  1  b/store_data hold a valid operand
- out_ready  in  1  ALU consumes the operand this cycle
- b  out  WIDTH  registered ALU operand B
- store_data  out  WIDTH  registered forwarded rs2, independent of ALUsrc
- b_from_imm  out  1  registered copy of ALUsrc for the held operand

## Operation
- rs2_eff: fwd_data of the lowest-index i with fwd_hit[i]=1; readData2 if fwd_hit is all zero.
- imm_ext, always exactly WIDTH bits:
  - 00: zero-extend imm.
  - 01: sign-extend imm from bit IMM_W-1.
  - 10: imm << (WIDTH-IMM_W), low bits zero. When IMM_W=WIDTH, this equals imm.
  - 11: sign-extend, then shift left by 2, truncated to WIDTH.
- b_next = ALUsrc ? imm_ext : rs2_eff; store_data_next = rs2_eff.
- Handshake:
  - in_ready = !out_valid || out_ready. Combinational from out_ready and state.
  - Accept when in_valid && in_ready. On accept, load b, store_data and b_from_imm, and set out_valid=1.
  - The output is consumed when out_valid && out_ready. If nothing is accepted in the same cycle, out_valid clears.
  - Accept and consume in the same cycle give back-to-back transfer, one per cycle, with no bubble.
  - While out_valid=1 && out_ready=0: b, store_data and b_from_imm hold constant. In this state in_ready=0 and input changes are ignored.
- Flush, which beats accept: on a clock edge with flush=1, out_valid clears and no input is captured, even if in_valid && in_ready. Data registers keep their values; they are don't-care while out_valid=0.
- Data registers load only on accept. This keeps toggling low.

## Timing
- Latency is 1 cycle: inputs accepted at edge N appear on b/store_data with out_valid=1 after edge N.
- Throughput is 1 operand per cycle when out_ready is held high.
- Reset: while rst_n=0, asynchronously force out_valid=0, b=0, store_data=0, b_from_imm=0.
  - in_ready reads 1 during and after reset.
  - Reset asserted mid-transfer drops the held operand immediately, not at the next edge.
- Reset release is synchronous to clk. The first edge with rst_n=1 may accept.
- The only combinational input-to-output path is out_ready to in_ready. There is no path from the data inputs to any output.
- When fwd_hit has several bits set, only the priority rule applies. Lower index wins, with no error flag.

## Test plan
All scenarios use WIDTH=32, IMM_W=16, NUM_FWD=2.
- Reset: hold a valid operand with out_ready=0, then pulse rst_n low between edges. Required response: out_valid=0 and b=0 before the next edge, and in_ready=1.
- Basic register path: readData2=5, ALUsrc=0, fwd_hit=00, in_valid=1, out_ready=1. Required response: after 1 edge, b=5, store_data=5, b_from_imm=0, out_valid=1.
- Immediate modes: imm=16'hFFFC, ALUsrc=1 in successive cycles. Required b values:
  - mode 00: 32'h0000FFFC
  - mode 01: 32'hFFFFFFFC
  - mode 10: 32'hFFFC0000
  - mode 11: 32'hFFFFFFF0
- Forwarding: readData2=1, fwd_data[0]=32'h11, fwd_data[1]=32'h22. Required responses:
  - fwd_hit=11, ALUsrc=0: b=32'h11.
  - fwd_hit=10: b=32'h22.
  - ALUsrc=1, imm=9, mode 00, fwd_hit=10: b=9, store_data=32'h22, b_from_imm=1.
- Backpressure: with out_valid=1, hold out_ready=0 for 3 cycles while readData2 changes every cycle. Required: in_ready=0, and b unchanged for all 3 cycles. Then set out_ready=1 with in_valid=1, readData2=7: the next edge gives b=7 and out_valid=1, with no bubble.
- Flush: in_valid=1, in_ready=1, flush=1 on the same edge. Required: out_valid=0 after the edge. The following cycle, with flush=0, in_valid=1 and readData2=3, gives b=3 after the next edge.
